// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_pkg
//  Brief    : Shared widths and constants for the scoreboarded register file.
//  Revision : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int ZERO_REG       = 0;

    localparam logic [DEFAULT_DATA_W-1:0] RESET_DATA = '0;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : rf_scoreboard
//  Brief    : Per-register pending-producer bits with flush and registered count.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_issue,
    input  logic [ADDR_W-1:0]     i_issue_reg,
    input  logic                  i_clear,
    input  logic [ADDR_W-1:0]     i_clear_reg,
    input  logic                  i_flush,
    output logic [2**ADDR_W-1:0]  o_busy,
    output logic [ADDR_W:0]       o_busy_count
);

    localparam int c_depth = 2**ADDR_W;

    logic [c_depth-1:0] r_busy;
    logic [c_depth-1:0] w_busy_nxt;
    logic [ADDR_W:0]    r_count;
    logic [ADDR_W:0]    w_count_nxt;

    // Issue is applied after the write-clear so a same-cycle issue keeps the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_flush) begin
            w_busy_nxt = '0;
        end else begin
            if (i_clear) begin
                w_busy_nxt[i_clear_reg] = 1'b0;
            end
            if (i_issue) begin
                w_busy_nxt[i_issue_reg] = 1'b1;
            end
        end
        w_busy_nxt[ZERO_REG] = 1'b0;
    end

    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < c_depth; i++) begin
            w_count_nxt = w_count_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign o_busy       = r_busy;
    assign o_busy_count = r_count;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb
//  Brief    : 2-read/1-write register file with optional write forwarding and
//             a pending-producer scoreboard driving the Stall output.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] Read1,
    input  logic [ADDR_W-1:0] Read2,
    output logic [DATA_W-1:0] Data1,
    output logic [DATA_W-1:0] Data2,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              Issue,
    input  logic [ADDR_W-1:0] IssueReg,
    input  logic              Flush,
    output logic              Stall,
    output logic [ADDR_W:0]   BusyCount
);

    localparam int                c_depth      = 2**ADDR_W;
    localparam bit                c_bypass_en  = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] c_zero_idx   = ADDR_W'(ZERO_REG);
    localparam logic [DATA_W-1:0] c_reset_word = DATA_W'(RESET_DATA);

    logic [DATA_W-1:0]  r_rf [c_depth];
    logic [c_depth-1:0] w_busy;
    logic               w_wr_en;
    logic               w_fwd1;
    logic               w_fwd2;
    logic               w_pend1;
    logic               w_pend2;

    assign w_wr_en = RegWrite && (WriteReg != c_zero_idx);

    // Entry 0 is never written, so it keeps its reset value forever.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_rf[i] <= c_reset_word;
            end
        end else if (w_wr_en) begin
            r_rf[WriteReg] <= WriteData;
        end
    end

    // Forwarding is gated by reset_n so reset forces zero reads even mid-write.
    assign w_fwd1 = c_bypass_en && reset_n && w_wr_en && (WriteReg == Read1);
    assign w_fwd2 = c_bypass_en && reset_n && w_wr_en && (WriteReg == Read2);

    assign Data1 = (Read1 == c_zero_idx) ? c_reset_word :
                   w_fwd1                ? WriteData    : r_rf[Read1];
    assign Data2 = (Read2 == c_zero_idx) ? c_reset_word :
                   w_fwd2                ? WriteData    : r_rf[Read2];

    assign w_pend1 = w_busy[Read1] && (Read1 != c_zero_idx) && !w_fwd1;
    assign w_pend2 = w_busy[Read2] && (Read2 != c_zero_idx) && !w_fwd2;
    assign Stall   = w_pend1 || w_pend2;

    rf_scoreboard #(
        .ADDR_W       (ADDR_W)
    ) u_scoreboard (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_issue      (Issue),
        .i_issue_reg  (IssueReg),
        .i_clear      (w_wr_en),
        .i_clear_reg  (WriteReg),
        .i_flush      (Flush),
        .o_busy       (w_busy),
        .o_busy_count (BusyCount)
    );

endmodule : reg_file_sb
`default_nettype wire

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: register index width; depth = 2**ADDR_W.
REQ-003 Parameter BYPASS, default 1: 1 = write-to-read forwarding in the same cycle; 0 = no forwarding.
REQ-004 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Ports Read1, Read2, input, ADDR_W: read register indices.
REQ-007 Ports Data1, Data2, output, DATA_W: read data.
REQ-008 Port RegWrite, input, 1: write enable.
REQ-009 Port WriteReg, input, ADDR_W: write index.
REQ-010 Port WriteData, input, DATA_W: write data.
REQ-011 Port Issue, input, 1: marks a register as having a pending producer.
REQ-012 Port IssueReg, input, ADDR_W: index of that pending destination.
REQ-013 Port Flush, input, 1: clears all pending marks.
REQ-014 Port Stall, output, 1: a read operand is pending.
REQ-015 Port BusyCount, output, ADDR_W+1: number of registers currently pending.

Function
REQ-016 Register 0 SHALL always read 0; writes to it SHALL be ignored; it SHALL never be marked busy.
REQ-017 Reads SHALL be combinational from the stored array (zero cycles of latency).
REQ-018 With BYPASS=1, when RegWrite=1, WriteReg=ReadX and ReadX!=0, DataX SHALL equal WriteData in the same cycle.
REQ-019 With BYPASS=0, DataX SHALL show the old value until the clock edge after the write.
REQ-020 When RegWrite=1 and WriteReg!=0, RF[WriteReg] SHALL be updated to WriteData at the clock edge.
REQ-021 busy[WriteReg] SHALL be cleared at the same edge as that write.
REQ-022 When Issue=1 and IssueReg!=0, busy[IssueReg] SHALL be set at the clock edge.
  - Issue to a register that is already busy is legal (WAW); the bit stays set.
REQ-023 If Issue and a write target the same register in the same cycle, Issue SHALL win: busy stays set and the data is still written.
REQ-024 Flush=1 SHALL clear every busy bit at the clock edge.
  - Flush overrides a same-cycle Issue.
  - Flush SHALL NOT block a same-cycle RegWrite data update.
REQ-025 Stall SHALL equal pend(Read1) OR pend(Read2), where pend(r) = busy[r] AND r!=0.
  - With BYPASS=1, pend(r) is additionally masked when RegWrite=1 and WriteReg=r in that cycle.
REQ-026 BusyCount SHALL equal the population count of the busy bits, updated registered at the same edge as the busy vector.
  - Range 0 .. 2**ADDR_W-1; it SHALL never wrap.
REQ-027 Stall SHALL be purely combinational from the current busy state and inputs; there SHALL be no internal stall state.

Reset
REQ-028 While reset_n=0, all registers, all busy bits and BusyCount SHALL be 0, asynchronously.
  - Data1=Data2=0, Stall=0.
REQ-029 While reset_n=0, RegWrite, Issue and bypass forwarding SHALL be ignored.
REQ-030 Deassertion of reset_n SHALL take effect at the next clock edge.
  - A reset asserted in the middle of any operation SHALL discard all pending state.

Structure
REQ-031 Shared package reg_file_pkg SHALL hold:
  - the default DATA_W and ADDR_W values;
  - the ZERO_REG index constant;
  - the reset data constant (all zeros).
REQ-032 Scoreboard logic (busy vector, Flush, BusyCount) SHALL live in sub-module rf_scoreboard.
  - The data array and bypass logic SHALL remain in reg_file_sb.

Verification
REQ-033 Reset, then read all indices -> all return 0x00000000; Stall=0; BusyCount=0.
REQ-034 Write 0xDEADBEEF to r5 with Read1=5 in the same cycle.
  - BYPASS=1 -> Data1=0xDEADBEEF in that cycle.
  - BYPASS=0 -> Data1=0 until the next edge, then 0xDEADBEEF.
REQ-035 Write 0x12345678 to r0 -> Data1 with Read1=0 stays 0; Issue r0 -> BusyCount stays 0.
REQ-036 Issue r3 and r7; next cycle Read2=3 -> Stall=1, BusyCount=2.
  - Write r3 -> Stall drops to 0 in the same cycle (BYPASS=1); BusyCount=1 after the edge.
REQ-037 Issue r4 and write r4 in the same cycle -> after the edge busy[4]=1 and RF[4] holds the new data.
  - Flush with a same-cycle Issue r9 -> BusyCount=0.
REQ-038 Assert reset_n low asynchronously mid-cycle with 3 registers busy and r2=0xA5A5A5A5.
  - BusyCount=0 and r2 reads 0 immediately, without waiting for a clock edge.
